dport_latency_mem: RTL and testbench

Data-port responder for the `riscv_core` `mem_d_*` interface. It accepts load, store and cache-maintenance requests, queues them in order, and answers each one after a programmable fixed latency with the request tag echoed back. Its storage is a word-organised backing RAM. The block replaces the zero-wait data side of `tcm_mem` in core benches, so that the core's LSU is exercised against back-pressure, multi-cycle responses and bus errors.

---
 rtl/dport_latency_mem.sv | 121 ++++++++++++
 tb/tb_dport_latency_mem.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dport_latency_mem.sv
// dport_latency_mem: fixed-latency in-order data-port responder with a word-organised backing RAM.
// Ports: clk_i/rst_i (sync active-high reset); mem_d_* request side (addr, data_wr, rd, wr byte
// enables, cacheable (unused), req_tag, invalidate/writeback/flush); mem_d_* response side
// (data_rd, accept, ack, error, resp_tag). Optional macro DPORT_STALL_INJECT_EN adds LFSR accept stalls.
module dport_latency_mem #(
    parameter int          DEPTH_WORDS = 16384,
    parameter int          LATENCY     = 2,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [10:0] mem_d_resp_tag_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int QW = $clog2(QUEUE_DEPTH);

    logic [31:0]            ram [DEPTH_WORDS];
    logic [10:0]            q_tag [QUEUE_DEPTH];
    logic [31:0]            q_data [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_err, ripe;
    logic [3:0]             q_due [QUEUE_DEPTH];
    logic [QW:0]            count;
    logic [QW-1:0]          wp, rp;
    logic [3:0]             cyc, cyc_n;
    logic [AW-1:0]          widx;
    logic [31:0]            merged, rdata, data_q;
    logic [10:0]            tag_q;
    logic                   req, push, push_q, pop, bypass, in_range, ack_q, err_q;
    logic                   unused;

    assign unused   = ^{mem_d_cacheable_i, mem_d_addr_i[1:0]};
    assign req      = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
    assign in_range = {2'b00, mem_d_addr_i[31:2]} < 32'(DEPTH_WORDS);
    assign widx     = mem_d_addr_i[AW+1:2];
    assign cyc_n    = cyc + 4'd1;
    assign push     = req & mem_d_accept_o;
    // With LATENCY 1 an empty queue must answer straight from the request, since the
    // registered ack has to appear on the very next cycle.
    assign bypass   = push && LATENCY == 1 && count == '0;
    assign push_q   = push && !bypass;
    // An entry can become due while still behind older ones; ripe remembers that so a
    // late head is not missed once the modulo-16 counter has moved past its due value.
    assign pop      = count != '0 && (ripe[rp] || q_due[rp] == cyc_n);
    assign rdata    = (in_range && mem_d_rd_i) ? merged : 32'd0;

    always_comb begin
        merged = ram[widx];
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = mem_d_wr_i[i] ? mem_d_data_wr_i[8*i +: 8] : ram[widx][8*i +: 8];
    end

`ifdef DPORT_STALL_INJECT_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk_i)
        if (rst_i) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign mem_d_accept_o = !rst_i && count < (QW+1)'(QUEUE_DEPTH) && lfsr[1:0] != 2'b00;
`else
    assign mem_d_accept_o = !rst_i && count < (QW+1)'(QUEUE_DEPTH);
`endif

    always_ff @(posedge clk_i)
        if (push && in_range)
            for (int i = 0; i < 4; i++)
                if (mem_d_wr_i[i]) ram[widx][8*i +: 8] <= mem_d_data_wr_i[8*i +: 8];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count  <= '0;
            wp     <= '0;
            rp     <= '0;
            cyc    <= '0;
            ripe   <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
            tag_q  <= '0;
        end else begin
            cyc <= cyc_n;
            for (int i = 0; i < QUEUE_DEPTH; i++)
                if (q_due[i] == cyc_n) ripe[i] <= 1'b1;
            if (push_q) begin
                q_tag[wp]  <= mem_d_req_tag_i;
                q_data[wp] <= rdata;
                q_err[wp]  <= !in_range;
                q_due[wp]  <= cyc + 4'(LATENCY);
                ripe[wp]   <= LATENCY == 1;
                wp         <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            count  <= count + (QW+1)'(push_q) - (QW+1)'(pop);
            ack_q  <= pop || bypass;
            tag_q  <= pop ? q_tag[rp]  : bypass ? mem_d_req_tag_i : 11'd0;
            data_q <= pop ? q_data[rp] : bypass ? rdata : 32'd0;
            err_q  <= pop ? q_err[rp]  : bypass && !in_range;
        end
    end

    assign mem_d_ack_o      = ack_q && !rst_i;
    assign mem_d_error_o    = err_q && !rst_i;
    assign mem_d_data_rd_o  = rst_i ? 32'd0 : data_q;
    assign mem_d_resp_tag_o = rst_i ? 11'd0 : tag_q;

    task automatic write(input logic [31:0] addr, input logic [7:0] b);
        ram[addr[AW+1:2]][{addr[1:0], 3'b000} +: 8] <= b;
    endtask
endmodule

// File: tb/tb_dport_latency_mem.sv
// tb_dport_latency_mem: directed vector table plus multi-cycle sequences for dport_latency_mem.
module tb_dport_latency_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata;
    logic        rd, inv, wb, fl;
    logic [3:0]  wr;
    logic [10:0] tag;
    logic [31:0] data_a, data_b;
    logic        acc_a, acc_b, ack_a, ack_b, err_a, err_b;
    logic [10:0] rtag_a, rtag_b;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    dport_latency_mem #(.LATENCY(2), .QUEUE_DEPTH(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .mem_d_addr_i(addr), .mem_d_data_wr_i(wdata),
        .mem_d_rd_i(rd), .mem_d_wr_i(wr), .mem_d_cacheable_i(1'b1), .mem_d_req_tag_i(tag),
        .mem_d_invalidate_i(inv), .mem_d_writeback_i(wb), .mem_d_flush_i(fl),
        .mem_d_data_rd_o(data_a), .mem_d_accept_o(acc_a), .mem_d_ack_o(ack_a),
        .mem_d_error_o(err_a), .mem_d_resp_tag_o(rtag_a));

    dport_latency_mem #(.LATENCY(8), .QUEUE_DEPTH(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .mem_d_addr_i(addr), .mem_d_data_wr_i(wdata),
        .mem_d_rd_i(rd), .mem_d_wr_i(wr), .mem_d_cacheable_i(1'b0), .mem_d_req_tag_i(tag),
        .mem_d_invalidate_i(inv), .mem_d_writeback_i(wb), .mem_d_flush_i(fl),
        .mem_d_data_rd_o(data_b), .mem_d_accept_o(acc_b), .mem_d_ack_o(ack_b),
        .mem_d_error_o(err_b), .mem_d_resp_tag_o(rtag_b));

    typedef struct {
        logic        rd;
        logic [3:0]  wr;
        logic        inv;
        logic [31:0] addr;
        logic [31:0] data;
        logic [10:0] tag;
        logic        e_ack;
        logic [10:0] e_tag;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t v[13];

    function automatic vec_t mk(input logic r, input logic [3:0] w, input logic i,
                                input logic [31:0] a, input logic [31:0] d, input logic [10:0] t,
                                input logic ea, input logic [10:0] et, input logic [31:0] ed,
                                input logic ee);
        vec_t x;
        x.rd = r; x.wr = w; x.inv = i; x.addr = a; x.data = d; x.tag = t;
        x.e_ack = ea; x.e_tag = et; x.e_data = ed; x.e_err = ee;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rd = 1'b0; wr = 4'h0; inv = 1'b0; wb = 1'b0; fl = 1'b0;
        addr = 32'd0; wdata = 32'd0; tag = 11'd0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        next();
        rst = 1'b0;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) dut_a.write(a + 32'(i), w[8*i +: 8]);
    endtask

    initial begin
        logic [10:0] bt;
        logic [10:0] nt;
        logic [10:0] expq[$];
        int          nacc, gaps;
        idle();
        rst = 1'b1;
        v[0]  = mk(1'b0, 4'hF, 1'b0, 32'h100,   32'hDEADBEEF, 11'd5,  1'b0, 11'd0,  32'h0,        1'b0);
        v[1]  = mk(1'b1, 4'h0, 1'b0, 32'h100,   32'h0,        11'd6,  1'b0, 11'd0,  32'h0,        1'b0);
        v[2]  = mk(1'b0, 4'h5, 1'b0, 32'h200,   32'hAABBCCDD, 11'd7,  1'b1, 11'd5,  32'h0,        1'b0);
        v[3]  = mk(1'b1, 4'h0, 1'b0, 32'h200,   32'h0,        11'd8,  1'b1, 11'd6,  32'hDEADBEEF, 1'b0);
        v[4]  = mk(1'b0, 4'hF, 1'b0, 32'h10000, 32'hDEADBEEF, 11'd9,  1'b1, 11'd7,  32'h0,        1'b0);
        v[5]  = mk(1'b1, 4'h0, 1'b0, 32'h10000, 32'h0,        11'd10, 1'b1, 11'd8,  32'h11BB33DD, 1'b0);
        v[6]  = mk(1'b1, 4'h0, 1'b0, 32'h0,     32'h0,        11'd11, 1'b1, 11'd9,  32'h0,        1'b1);
        v[7]  = mk(1'b1, 4'h3, 1'b0, 32'h104,   32'h0000CAFE, 11'd12, 1'b1, 11'd10, 32'h0,        1'b1);
        v[8]  = mk(1'b0, 4'h0, 1'b0, 32'h0,     32'h0,        11'd0,  1'b1, 11'd11, 32'h0BADF00D, 1'b0);
        v[9]  = mk(1'b0, 4'h0, 1'b1, 32'h0,     32'h0,        11'd13, 1'b1, 11'd12, 32'h1234CAFE, 1'b0);
        v[10] = mk(1'b0, 4'h0, 1'b0, 32'h0,     32'h0,        11'd0,  1'b0, 11'd0,  32'h0,        1'b0);
        v[11] = mk(1'b0, 4'h0, 1'b0, 32'h0,     32'h0,        11'd0,  1'b1, 11'd13, 32'h0,        1'b0);
        v[12] = mk(1'b0, 4'h0, 1'b0, 32'h0,     32'h0,        11'd0,  1'b0, 11'd0,  32'h0,        1'b0);
        next();
        preload(32'h200, 32'h11223344);
        preload(32'h0,   32'h0BADF00D);
        preload(32'h104, 32'h12345678);
        @(negedge clk);
        chk("rst_accept_a", 32'(acc_a), 32'd0);
        chk("rst_accept_b", 32'(acc_b), 32'd0);
        chk("rst_ack_a",    32'(ack_a), 32'd0);
        chk("rst_data_a",   data_a,     32'd0);
        chk("rst_tag_a",    32'(rtag_a), 32'd0);
        next();
        rst = 1'b0;

`ifndef DPORT_STALL_INJECT_EN
        for (int k = 0; k < 13; k++) begin
            rd = v[k].rd; wr = v[k].wr; inv = v[k].inv;
            addr = v[k].addr; wdata = v[k].data; tag = v[k].tag;
            @(negedge clk);
            chk($sformatf("v%0d_accept", k), 32'(acc_a), 32'd1);
            chk($sformatf("v%0d_ack", k),    32'(ack_a), 32'(v[k].e_ack));
            chk($sformatf("v%0d_tag", k),    32'(rtag_a), 32'(v[k].e_tag));
            chk($sformatf("v%0d_data", k),   data_a, v[k].e_data);
            chk($sformatf("v%0d_err", k),    32'(err_a), 32'(v[k].e_err));
            next();
        end

        do_reset();
        bt = 11'd0;
        nacc = 0;
        for (int c = 0; c < 12; c++) begin
            idle();
            rd = c <= 8;
            addr = 32'h40;
            tag = bt;
            @(negedge clk);
            chk($sformatf("bp%0d_accept", c), 32'(acc_b), 32'((c < 4) || (c >= 8)));
            chk($sformatf("bp%0d_ack", c),    32'(ack_b), 32'(c >= 8));
            if (c >= 8) chk($sformatf("bp%0d_tag", c), 32'(rtag_b), 32'(c - 8));
            if (rd && acc_b) begin
                bt++;
                if (c < 8) nacc++;
            end
            next();
        end
        chk("bp_accepts", 32'(nacc), 32'd4);

        idle();
        repeat (12) next();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            rd = 1'b1; addr = 32'h100; tag = 11'(20 + c);
            @(negedge clk);
            chk($sformatf("mr%0d_accept", c), 32'(acc_b), 32'd1);
            next();
        end
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("mr_rst_accept_b", 32'(acc_b), 32'd0);
        chk("mr_rst_accept_a", 32'(acc_a), 32'd0);
        chk("mr_rst_ack_b",    32'(ack_b), 32'd0);
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_post_accept_b", 32'(acc_b), 32'd1);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            chk($sformatf("mr%0d_noack_b", c), 32'(ack_b), 32'd0);
            chk($sformatf("mr%0d_noack_a", c), 32'(ack_a), 32'd0);
            next();
        end
`endif

        do_reset();
        nt = 11'd0;
        gaps = 0;
        for (int c = 0; c < 1100; c++) begin
            idle();
            rd = (c < 1000) && ($urandom_range(0, 3) != 0);
            addr = 32'($urandom_range(0, 4095)) << 2;
            tag = nt;
            @(negedge clk);
            if (ack_a) begin
                chk("rnd_tag", 32'(rtag_a), expq.size() != 0 ? 32'(expq.pop_front()) : 32'hFFFFFFFF);
                chk("rnd_err", 32'(err_a), 32'd0);
            end
            if (rd && !acc_a && expq.size() < 4) gaps++;
            if (rd && acc_a) begin
                expq.push_back(nt);
                nt++;
            end
            next();
        end
        chk("rnd_drained", 32'(expq.size()), 32'd0);
`ifdef DPORT_STALL_INJECT_EN
        chk("rnd_gaps_seen", 32'(gaps > 0), 32'd1);
`else
        chk("rnd_no_gaps", 32'(gaps), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
